// File: rtl/cpuhead_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpuhead_pkg: shared CPU-head types and helpers                   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package cpuhead_pkg;

    typedef logic [4:0]  regidx_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        logic    valid;
        regidx_t wa;
        word_t   wd;
    } wb_req_t;

    localparam int c_NUM_REGS = 32;

    function automatic logic [5:0] popcnt31(input logic [31:1] v);
        logic [5:0] cnt;
        cnt = 6'd0;
        for (int i = 1; i < c_NUM_REGS; i++) begin
            cnt = cnt + {5'd0, v[i]};
        end
        return cnt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rf_wb_sched_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rr_arb2: two-requester round-robin arbiter, one-hot grants       |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rr_arb2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    // Set when requester 0 (A) wins a tie.
    logic r_prio_a;

    always_comb begin
        o_gnt = 2'b00;
        if (resetn) begin
            if (i_req == 2'b11) begin
                o_gnt = r_prio_a ? 2'b01 : 2'b10;
            end else begin
                o_gnt = i_req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prio_a <= 1'b1;
        end else if (o_gnt[0]) begin
            r_prio_a <= 1'b0;
        end else if (o_gnt[1]) begin
            r_prio_a <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rf_wb_sched.sv
`default_nettype none
// +------------------------------------------------------------------+
// | rf_wb_sched: regfile writeback arbiter with busy scoreboard      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module rf_wb_sched
    import cpuhead_pkg::*;
(
    input  logic    clk,
    input  logic    resetn,
    input  logic    i_a_valid,
    input  regidx_t i_a_wa,
    input  word_t   i_a_wd,
    output logic    o_a_ready,
    input  logic    i_b_valid,
    input  regidx_t i_b_wa,
    input  word_t   i_b_wd,
    output logic    o_b_ready,
    input  logic    i_claim_valid,
    input  regidx_t i_claim_idx,
    input  regidx_t i_q1_idx,
    input  regidx_t i_q2_idx,
    output logic    o_q1_busy,
    output logic    o_q2_busy,
    output logic    o_rf_we,
    output regidx_t o_rf_wa,
    output word_t   o_rf_wd,
    output logic [5:0] o_pend_cnt,
    output logic    o_err_dup
);

    logic [1:0]  w_gnt;
    logic        w_gnt_a;
    logic        w_gnt_b;
    logic [31:0] w_busy_full;
    logic [31:0] w_set;
    logic [31:0] w_clr;
    logic [31:0] w_busy_nxt;
    logic        w_dup;

    logic        r_rf_we;
    regidx_t     r_rf_wa;
    word_t       r_rf_wd;
    logic [31:1] r_busy;
    logic [5:0]  r_pend_cnt;
    logic        r_err_dup;

    rr_arb2 u_arb (
        .clk    (clk),
        .resetn (resetn),
        .i_req  ({i_b_valid, i_a_valid}),
        .o_gnt  (w_gnt)
    );

    assign w_gnt_a   = w_gnt[0];
    assign w_gnt_b   = w_gnt[1];
    assign o_a_ready = w_gnt_a;
    assign o_b_ready = w_gnt_b;

    // r0 is never tracked, so bit 0 of the full vector is always 0.
    assign w_busy_full = {r_busy, 1'b0};
    assign w_set       = (i_claim_valid && (i_claim_idx != 5'd0)) ? (32'd1 << i_claim_idx) : 32'd0;
    assign w_clr       = w_gnt_b ? (32'd1 << i_b_wa) : 32'd0;
    assign w_busy_nxt  = ((w_busy_full & ~w_clr) | w_set) & ~32'd1;
    assign w_dup       = |(w_set & w_busy_full & ~w_clr);

    // Also busy while the write is in flight, until the regfile holds it.
    assign o_q1_busy = (i_q1_idx != 5'd0) &&
                       (w_busy_full[i_q1_idx] ||
                        (w_gnt_b && (i_b_wa == i_q1_idx)) ||
                        (r_rf_we && (r_rf_wa == i_q1_idx)));
    assign o_q2_busy = (i_q2_idx != 5'd0) &&
                       (w_busy_full[i_q2_idx] ||
                        (w_gnt_b && (i_b_wa == i_q2_idx)) ||
                        (r_rf_we && (r_rf_wa == i_q2_idx)));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rf_we    <= 1'b0;
            r_rf_wa    <= 5'd0;
            r_rf_wd    <= 32'd0;
            r_busy     <= '0;
            r_pend_cnt <= 6'd0;
            r_err_dup  <= 1'b0;
        end else begin
            if (w_gnt_a) begin
                r_rf_we <= (i_a_wa != 5'd0);
                r_rf_wa <= i_a_wa;
                r_rf_wd <= i_a_wd;
            end else if (w_gnt_b) begin
                r_rf_we <= (i_b_wa != 5'd0);
                r_rf_wa <= i_b_wa;
                r_rf_wd <= i_b_wd;
            end else begin
                r_rf_we <= 1'b0;
            end
            r_busy     <= w_busy_nxt[31:1];
            r_pend_cnt <= popcnt31(w_busy_nxt[31:1]);
            if (w_dup) begin
                r_err_dup <= 1'b1;
            end
        end
    end

    assign o_rf_we    = r_rf_we;
    assign o_rf_wa    = r_rf_wa;
    assign o_rf_wd    = r_rf_wd;
    assign o_pend_cnt = r_pend_cnt;
    assign o_err_dup  = r_err_dup;

endmodule
`default_nettype wire
